// File: rtl/fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp32_divider
// Description : Iterative IEEE-754 single-precision divider, res = a / b.
//               Radix-2 restoring mantissa division producing one quotient
//               bit per cycle, truncating rounding. Valid/ready handshake
//               on both the operand and the result side.
//
// Ports       : clk       - clock, rising-edge
//               rst       - synchronous active-high reset
//               in_valid  - operands a/b valid
//               in_ready  - divider idle, operands accepted when in_valid=1
//               a, b      - dividend / divisor, FP32
//               out_valid - res valid (held until out_ready)
//               out_ready - consumer accepts res
//               res       - quotient, FP32
//
// Config      : `define FP_DIV_SPECIAL_EN to decode NaN/inf/zero operands
//               at accept and to saturate/flush out-of-range exponents.
//               Without it every operand takes the divide path and the
//               exponent wraps modulo 256.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);

  // 24 mantissa bits plus one normalisation bit
  localparam int QBITS = 25;
  localparam logic [4:0] c_cnt_init = 5'(QBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic              r_sign;
  logic [23:0]       r_mb;
  logic [9:0]        r_exp_diff;
  logic [QBITS-1:0]  r_rem;
  logic [QBITS-1:0]  r_q;
  logic [4:0]        r_cnt;
  logic [31:0]       r_res;

  logic              w_accept;
  logic              w_ge;
  logic [QBITS-1:0]  w_rem_sub;
  logic [9:0]        w_norm_exp;
  logic [22:0]       w_norm_mant;
  logic [31:0]       w_norm_res;
  logic              w_is_special;

  assign res      = r_res;
  assign w_accept = in_valid && (r_state == S_IDLE);

  // --------------------------------------------------------------------------
  // Special-operand decode (optional)
  // --------------------------------------------------------------------------
`ifdef FP_DIV_SPECIAL_EN
  logic        r_special;
  logic [31:0] r_special_res;
  logic [31:0] w_special_res;
  logic        w_sign_in;
  logic        w_a_zero, w_a_nan, w_a_inf;
  logic        w_b_zero, w_b_nan, w_b_inf;
  logic        w_sp_nan, w_sp_inf, w_sp_zero;

  assign w_sign_in = a[31] ^ b[31];
  // Exponent field 0 is treated as zero regardless of fraction (flush)
  assign w_a_zero  = (a[30:23] == 8'h00);
  assign w_b_zero  = (b[30:23] == 8'h00);
  assign w_a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign w_b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign w_a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign w_b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);

  always_comb begin
    w_sp_nan  = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    w_sp_inf  = !w_sp_nan && ((w_b_zero && !w_a_zero) || (w_a_inf && !w_b_inf));
    w_sp_zero = !w_sp_nan && ((w_a_zero && !w_b_zero) || (w_b_inf && !w_a_inf));
    w_is_special = w_sp_nan || w_sp_inf || w_sp_zero;
    if (w_sp_nan) begin
      w_special_res = 32'h7FC0_0000;
    end else if (w_sp_inf) begin
      w_special_res = {w_sign_in, 8'hFF, 23'h0};
    end else begin
      w_special_res = {w_sign_in, 31'h0};
    end
  end
`else
  assign w_is_special = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Division step: compare, conditionally subtract, shift
  // --------------------------------------------------------------------------
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  // After a step the remainder is below mb (< 2^24), so the shift cannot
  // lose a set bit.

  // --------------------------------------------------------------------------
  // Normalisation: quotient lies in [2^23, 2^25), one bit of adjustment
  // --------------------------------------------------------------------------
  always_comb begin
    if (r_q[QBITS-1]) begin
      w_norm_mant = r_q[23:1];
      w_norm_exp  = r_exp_diff + 10'd127;
    end else begin
      w_norm_mant = r_q[22:0];
      w_norm_exp  = r_exp_diff + 10'd126;
    end
    w_norm_res = {r_sign, w_norm_exp[7:0], w_norm_mant};
`ifdef FP_DIV_SPECIAL_EN
    if (r_special) begin
      w_norm_res = r_special_res;
    end else if ($signed(w_norm_exp) >= 10'sd255) begin
      w_norm_res = {r_sign, 8'hFF, 23'h0};
    end else if ($signed(w_norm_exp) <= 10'sd0) begin
      w_norm_res = {r_sign, 31'h0};
    end
`endif
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Special operands skip the divide loop; one pass through NORM
          // lands the result in DONE one edge after accept.
          w_next_state = w_is_special ? S_NORM : S_DIV;
        end
      end
      S_DIV: begin
        if (r_cnt == 5'd0) begin
          w_next_state = S_NORM;
        end
      end
      S_NORM: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_mb       <= 24'h0;
      r_exp_diff <= 10'h0;
      r_rem      <= '0;
      r_q        <= '0;
      r_cnt      <= 5'd0;
      r_res      <= 32'h0;
`ifdef FP_DIV_SPECIAL_EN
      r_special     <= 1'b0;
      r_special_res <= 32'h0;
`endif
    end else begin
      if (w_accept) begin
        r_sign     <= a[31] ^ b[31];
        r_mb       <= {1'b1, b[22:0]};
        r_exp_diff <= {2'b00, a[30:23]} - {2'b00, b[30:23]};
        r_rem      <= {2'b01, a[22:0]};
        r_cnt      <= c_cnt_init;
`ifdef FP_DIV_SPECIAL_EN
        r_special     <= w_is_special;
        r_special_res <= w_special_res;
`endif
      end
      if (r_state == S_DIV) begin
        // Quotient bits arrive MSB first, so shifting in fills q[24]..q[0]
        r_q   <= {r_q[QBITS-2:0], w_ge};
        r_rem <= {w_rem_sub[QBITS-2:0], 1'b0};
        r_cnt <= r_cnt - 5'd1;
      end
      if (r_state == S_NORM) begin
        r_res <= w_norm_res;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_divider
// Description : Self-checking bench for fp32_divider: directed vectors,
//               random operands against an arithmetic reference model,
//               backpressure and reset-mid-operation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;

  fp32_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Reference: quotient = floor(ma * 2^24 / mb), then one-bit normalise,
  // exponent wraps to 8 bits.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] q;
    int          e;
    logic [7:0]  ex;
    logic [22:0] mant;
    ma = 64'h80_0000 + 64'(x[22:0]);
    mb = 64'h80_0000 + 64'(y[22:0]);
    q  = (ma << 24) / mb;
    e  = int'(x[30:23]) - int'(y[30:23]);
    if (q >= 64'h100_0000) begin
      ex   = 8'(e + 127);
      mant = q[23:1];
    end else begin
      ex   = 8'(e + 126);
      mant = q[22:0];
    end
    return {x[31] ^ y[31], ex, mant};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", {31'b0, in_ready}, 32'd1);
  endtask

  // Issue one operation and wait for out_valid; returns result and latency
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] r, output int lat);
    wait_idle();
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
    r = res;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    logic        seen;

    vecs[0] = '{"6.0/2.0",   32'h40C00000, 32'h40000000, 32'h40400000};
    vecs[1] = '{"1.0/3.0",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA};
    vecs[2] = '{"-8.0/0.5",  32'hC1000000, 32'h3F000000, 32'hC1800000};
    vecs[3] = '{"1.0/1.0",   32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[4] = '{"1.0/2.0",   32'h3F800000, 32'h40000000, 32'h3F000000};
    vecs[5] = '{"9.0/3.0",   32'h41100000, 32'h40400000, 32'h40400000};
    vecs[6] = '{"exp_wrap",  32'h7F000000, 32'h00800000, 32'h3E000000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 32'h0;
    b         = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_res",       res,                32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, r, lat);
      chk({vecs[i].name, "_res"}, r, vecs[i].r);
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'd26);
      pop();
      chk({vecs[i].name, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
      chk({vecs[i].name, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
    end

    // Random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, r, lat);
      chk($sformatf("rand%0d_%h_%h", i, ra, rb), r, ref_div(ra, rb));
      pop();
    end

    // Backpressure: hold the result, ignore new operands
    run_op(32'h40C00000, 32'h40000000, r, lat);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_res_c%0d", i), res, 32'h40400000);
      chk($sformatf("bp_valid_c%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_in_ready_c%0d", i), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    pop();
    chk("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
    chk("bp_out_valid_release", {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("bp_not_queued", {31'b0, seen}, 32'd0);

    // Reset on the 10th divide cycle
    wait_idle();
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_res",       res,                32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", {31'b0, seen}, 32'd0);

    // Operation after reset recovery
    run_op(32'hC1000000, 32'h3F000000, r, lat);
    chk("post_rst_res", r, 32'hC1800000);
    chk("post_rst_latency", 32'(lat), 32'd26);
    pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
